// File: rtl/bus_memory_responder.sv
// bus_memory_responder
//   Synchronous 16-bit memory slave for the 8088 core's external bus.
//   Serves as simulation RAM for the core. A one-cycle Req starts a bus cycle.
//   After WAIT_STATES idle cycles, the cycle completes with a one-cycle Ready pulse.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   Req        bus-cycle start strobe (RD_WR/Direction/Data_in valid with it)
//   RD_WR      0 = read, 1 = write
//   Direction  20-bit word address
//   Data_in    write data
//   Data_out   read data (holds between reads)
//   Data_oe    responder drives the shared data pin this cycle
//   Ready      one-cycle completion pulse
//   Busy       a bus cycle is in progress
//   Addr_err   with Ready, when the access fell outside the decoded window
module bus_memory_responder #(
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_STATES = 2,
  parameter logic [19:0] BASE_ADDR   = 20'h00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        RD_WR,
  input  logic [19:0] Direction,
  input  logic [15:0] Data_in,
  output logic [15:0] Data_out,
  output logic        Data_oe,
  output logic        Ready,
  output logic        Busy,
  output logic        Addr_err
);

  localparam int         DATA_W  = 16;
  localparam int         DEPTH   = 2 ** ADDR_BITS;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                 state;
  logic [3:0]             wait_cnt;

  // Bus-cycle attributes frozen at request capture
  logic                   cap_wr;
  logic                   cap_in_range;
  logic [ADDR_BITS-1:0]   cap_idx;
  logic [DATA_W-1:0]      cap_data;

  logic [DATA_W-1:0]      mem [DEPTH];

  logic                   req_in_range;
  logic                   accept;
  logic                   enter_resp;
  logic                   fin_wr;
  logic                   fin_in_range;
  logic [ADDR_BITS-1:0]   fin_idx;
  logic                   mem_we;

  assign req_in_range = (Direction[19:ADDR_BITS] == BASE_ADDR[19:ADDR_BITS]);
  assign accept       = (state == ST_IDLE) && Req;

  // With zero wait states the response cycle follows the request directly.
  // The completion data is then taken from the live bus, not from the capture registers.
  always_comb begin
    enter_resp   = 1'b0;
    fin_wr       = cap_wr;
    fin_in_range = cap_in_range;
    fin_idx      = cap_idx;
    if (state == ST_IDLE) begin
      enter_resp   = Req && (WAIT_STATES == 0);
      fin_wr       = RD_WR;
      fin_in_range = req_in_range;
      fin_idx      = Direction[ADDR_BITS-1:0];
    end else if (state == ST_WAIT) begin
      enter_resp   = (wait_cnt == 4'd1);
    end
  end

  // The write commits on the edge that ends RESP. A reset on that same edge takes priority and discards the write.
  assign mem_we = (state == ST_RESP) && cap_wr && cap_in_range && !reset;

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_wr       <= RD_WR;
      cap_in_range <= req_in_range;
      cap_idx      <= Direction[ADDR_BITS-1:0];
      cap_data     <= Data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[cap_idx] <= cap_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      Ready    <= 1'b0;
      Data_oe  <= 1'b0;
      Busy     <= 1'b0;
      Addr_err <= 1'b0;
      Data_out <= '0;
    end else begin
      Ready    <= 1'b0;
      Data_oe  <= 1'b0;
      Addr_err <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (Req) begin
            Busy     <= 1'b1;
            wait_cnt <= WS_LOAD;
            state    <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd1)
            state <= ST_RESP;
          else
            wait_cnt <= wait_cnt - 4'd1;
        end
        ST_RESP: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      // Registered completion outputs are valid for the single RESP cycle.
      if (enter_resp) begin
        Ready    <= 1'b1;
        Addr_err <= !fin_in_range;
        if (!fin_wr) begin
          Data_oe  <= 1'b1;
          Data_out <= fin_in_range ? mem[fin_idx] : 16'hFFFF;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_memory_responder.sv
module tb_bus_memory_responder;

  logic        clk;
  logic        rst;
  logic        req_i  [2];
  logic        wr_i   [2];
  logic [19:0] dir_i  [2];
  logic [15:0] din_i  [2];
  logic [15:0] do_o   [2];
  logic        oe_o   [2];
  logic        rdy_o  [2];
  logic        bsy_o  [2];
  logic        aerr_o [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Instance 0: default two wait states. Instance 1: zero wait states.
  bus_memory_responder #(.ADDR_BITS(10), .WAIT_STATES(2), .BASE_ADDR(20'h00000)) u_ws2 (
    .clk(clk), .reset(rst), .Req(req_i[0]), .RD_WR(wr_i[0]), .Direction(dir_i[0]),
    .Data_in(din_i[0]), .Data_out(do_o[0]), .Data_oe(oe_o[0]), .Ready(rdy_o[0]),
    .Busy(bsy_o[0]), .Addr_err(aerr_o[0]));

  bus_memory_responder #(.ADDR_BITS(10), .WAIT_STATES(0), .BASE_ADDR(20'h00000)) u_ws0 (
    .clk(clk), .reset(rst), .Req(req_i[1]), .RD_WR(wr_i[1]), .Direction(dir_i[1]),
    .Data_in(din_i[1]), .Data_out(do_o[1]), .Data_oe(oe_o[1]), .Ready(rdy_o[1]),
    .Busy(bsy_o[1]), .Addr_err(aerr_o[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model. A bus cycle is a record with its completion edge number.
  // Ready is expected on that edge, and the write lands one edge later.
  logic [15:0] mm    [2][1024];
  bit          mbusy [2];
  int          mresp [2];
  bit          mwr   [2];
  bit          min   [2];
  logic [9:0]  midx  [2];
  logic [15:0] mdat  [2];
  logic        e_rdy [2];
  logic        e_oe  [2];
  logic        e_bsy [2];
  logic        e_err [2];
  logic [15:0] e_do  [2];

  task automatic model_step(input int k, input int ws);
    bit was;
    if (rst) begin
      mbusy[k] = 0;
      e_rdy[k] = 0; e_oe[k] = 0; e_bsy[k] = 0; e_err[k] = 0; e_do[k] = 16'h0000;
    end else begin
      was = mbusy[k];
      e_rdy[k] = 0; e_oe[k] = 0; e_err[k] = 0;
      if (mbusy[k] && cyc == mresp[k] + 1) begin
        if (mwr[k] && min[k]) mm[k][midx[k]] = mdat[k];
        mbusy[k] = 0;
      end
      if (!was && req_i[k]) begin
        mbusy[k] = 1;
        mresp[k] = cyc + ws;
        mwr[k]   = wr_i[k];
        min[k]   = (dir_i[k] < 20'h00400);
        midx[k]  = dir_i[k][9:0];
        mdat[k]  = din_i[k];
      end
      if (mbusy[k] && cyc == mresp[k]) begin
        e_rdy[k] = 1;
        e_err[k] = !min[k];
        if (!mwr[k]) begin
          e_oe[k] = 1;
          e_do[k] = min[k] ? mm[k][midx[k]] : 16'hFFFF;
        end
      end
      e_bsy[k] = mbusy[k];
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    model_step(0, 2);
    model_step(1, 0);
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({rdy_o[k], oe_o[k], bsy_o[k], aerr_o[k]} !== {e_rdy[k], e_oe[k], e_bsy[k], e_err[k]} ||
            do_o[k] !== e_do[k]) begin
          fails++;
          $display("FAIL cycle_model inst%0d cyc%0d: got rdy/oe/bsy/err=%b%b%b%b dout=%h, want %b%b%b%b dout=%h",
                   k, cyc, rdy_o[k], oe_o[k], bsy_o[k], aerr_o[k], do_o[k],
                   e_rdy[k], e_oe[k], e_bsy[k], e_err[k], e_do[k]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic txn(input int k, input bit wr, input logic [19:0] a, input logic [15:0] d,
                     output logic [15:0] rd, output bit err, output int lat);
    @(negedge clk);
    req_i[k] = 1'b1; wr_i[k] = wr; dir_i[k] = a; din_i[k] = d;
    lat = -1; rd = '0; err = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      req_i[k] = 1'b0;
      if (rdy_o[k]) begin
        lat = i; rd = do_o[k]; err = aerr_o[k];
        break;
      end
    end
    if (lat < 0) begin
      tests++; fails++;
      $display("FAIL ready_timeout inst%0d addr %h: got no Ready, want Ready within 20 cycles", k, a);
    end
  endtask

  logic [15:0] rd;
  bit          err;
  int          lat;
  int          nrdy;
  int          rdy_at;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_i[k] = 0; wr_i[k] = 0; dir_i[k] = '0; din_i[k] = '0;
    end

    // Reset for three edges. Outputs are checked after the first edge.
    @(negedge clk);
    chk("reset_outputs_ws2", {do_o[0], 12'h0, rdy_o[0], oe_o[0], bsy_o[0], aerr_o[0]}, 32'h0);
    chk("reset_outputs_ws0", {do_o[1], 12'h0, rdy_o[1], oe_o[1], bsy_o[1], aerr_o[1]}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Write then read, issued one cycle after reset release.
    txn(0, 1, 20'h00010, 16'hA55A, rd, err, lat);
    chk("write_latency", lat, 3);
    txn(0, 0, 20'h00010, 16'h0000, rd, err, lat);
    chk("read_latency", lat, 3);
    chk("read_a55a", rd, 16'hA55A);

    // Window edges
    txn(0, 1, 20'h003FF, 16'h1234, rd, err, lat);
    txn(0, 1, 20'h00000, 16'h5678, rd, err, lat);
    txn(0, 0, 20'h003FF, 16'h0000, rd, err, lat);
    chk("read_top_word", rd, 16'h1234);
    txn(0, 0, 20'h00000, 16'h0000, rd, err, lat);
    chk("read_bottom_word", rd, 16'h5678);
    txn(0, 1, 20'h00400, 16'hDEAD, rd, err, lat);
    chk("oor_write_err", err, 1);
    chk("oor_write_latency", lat, 3);
    txn(0, 0, 20'h00400, 16'h0000, rd, err, lat);
    chk("oor_read_data", rd, 16'hFFFF);
    chk("oor_read_err", err, 1);
    txn(0, 0, 20'h00000, 16'h0000, rd, err, lat);
    chk("bottom_after_oor", rd, 16'h5678);
    chk("inrange_no_err", err, 0);

    // Req while busy is ignored, including the RESP cycle.
    txn(0, 1, 20'h00021, 16'h0BAD, rd, err, lat);
    @(negedge clk);
    req_i[0] = 1; wr_i[0] = 1; dir_i[0] = 20'h00020; din_i[0] = 16'h1111;
    nrdy = 0; rdy_at = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (rdy_o[0]) begin nrdy++; rdy_at = c; end
      req_i[0] = (c == 1 || c == 3); wr_i[0] = 1; dir_i[0] = 20'h00021; din_i[0] = 16'h2222;
    end
    chk("busy_one_ready", nrdy, 1);
    chk("busy_ready_cycle", rdy_at, 3);
    txn(0, 0, 20'h00021, 16'h0000, rd, err, lat);
    chk("busy_accept_after", lat, 3);
    chk("busy_ignored_write", rd, 16'h0BAD);
    txn(0, 0, 20'h00020, 16'h0000, rd, err, lat);
    chk("busy_first_write", rd, 16'h1111);

    // Reset during WAIT abandons the write.
    txn(0, 1, 20'h00030, 16'hCAFE, rd, err, lat);
    @(negedge clk);
    req_i[0] = 1; wr_i[0] = 1; dir_i[0] = 20'h00030; din_i[0] = 16'hBEEF;
    @(negedge clk);
    req_i[0] = 0;
    rst = 1'b1;
    nrdy = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (rdy_o[0]) nrdy++;
    end
    rst = 1'b0;
    chk("reset_mid_no_ready", nrdy, 0);
    txn(0, 0, 20'h00030, 16'h0000, rd, err, lat);
    chk("reset_mid_keeps_old", rd, 16'hCAFE);

    // Zero-wait-state instance, alternating write/read every other cycle.
    for (int i = 0; i < 4; i++) begin
      txn(1, 1, 20'h00100 + 20'(i), 16'h3C00 + 16'(i * 16'h0111), rd, err, lat);
      chk("ws0_write_latency", lat, 1);
      txn(1, 0, 20'h00100 + 20'(i), 16'h0000, rd, err, lat);
      chk("ws0_read_latency", lat, 1);
      chk("ws0_read_data", rd, 16'h3C00 + 16'(i * 16'h0111));
    end
    txn(1, 0, 20'hFFFFF, 16'h0000, rd, err, lat);
    chk("ws0_oor_read", {15'h0, err, rd}, {15'h0, 1'b1, 16'hFFFF});

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
